// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode encoding, FSM states, flag bit positions.
// Latency: n/a (package).
// Backpressure: n/a (package).
package exec_pkg;

   localparam int OPC_BITS = 5;
   typedef logic [OPC_BITS-1:0] opc_t;

   localparam opc_t OPC_NOP   = 5'b00000;
   localparam opc_t OPC_INC   = 5'b00001;
   localparam opc_t OPC_ADD   = 5'b00010;
   localparam opc_t OPC_ADC   = 5'b00011;
   localparam opc_t OPC_SBB   = 5'b00100;  // A - B - 1
   localparam opc_t OPC_SUB   = 5'b00101;
   localparam opc_t OPC_DEC   = 5'b00110;
   localparam opc_t OPC_PASS  = 5'b00111;
   localparam opc_t OPC_ROR   = 5'b01000;
   localparam opc_t OPC_LSR   = 5'b01001;
   localparam opc_t OPC_LSL   = 5'b01010;
   localparam opc_t OPC_SLX   = 5'b01011;  // shift left, LSB replicated
   localparam opc_t OPC_MUL   = 5'b01100;
   localparam opc_t OPC_OR    = 5'b11000;
   localparam opc_t OPC_XOR   = 5'b11010;
   localparam opc_t OPC_STORE = 5'b11011;
   localparam opc_t OPC_AND   = 5'b11100;
   localparam opc_t OPC_NOT   = 5'b11110;
   localparam opc_t OPC_LDI   = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MUL_RUN = 2'd1,
      ST_DONE    = 2'd2
   } exec_state_t;

   // flags_out = {zero, sign, carry}
   localparam int FLAG_C = 0;
   localparam int FLAG_S = 1;
   localparam int FLAG_Z = 2;

   // Every defined opcode writes back except NOP and STORE; undefined ones act as NOP.
   function automatic logic opc_writes(input opc_t opc);
      logic wr;
      case (opc)
         OPC_INC, OPC_ADD, OPC_ADC, OPC_SBB, OPC_SUB, OPC_DEC, OPC_PASS,
         OPC_ROR, OPC_LSR, OPC_LSL, OPC_SLX, OPC_MUL,
         OPC_OR, OPC_XOR, OPC_AND, OPC_NOT, OPC_LDI: wr = 1'b1;
         default:                                    wr = 1'b0;
      endcase
      return wr;
   endfunction

endpackage

// File: rtl/exec_alu_p.sv
// Combinational ALU for every single-cycle opcode; returns {carry, result} at DATA_W+1 bits.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when the result is registered.
//
// Ports: opc (operation), a/b (forwarded operands), imm (immediate), res ({carry, result}).
module exec_alu_p
   import exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  opc_t              opc,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W:0]   res
);

   localparam logic [DATA_W:0] ONE = {{DATA_W{1'b0}}, 1'b1};

   // Zero-extended operands: bit DATA_W of an add is the carry, of a subtract the borrow.
   logic [DATA_W:0] ax;
   logic [DATA_W:0] bx;

   assign ax = {1'b0, a};
   assign bx = {1'b0, b};

   always_comb begin
      res = '0;
      case (opc)
         OPC_INC:   res = ax + ONE;
         OPC_ADD:   res = ax + bx;
         OPC_ADC:   res = ax + bx + ONE;
         OPC_SBB:   res = ax - bx - ONE;
         OPC_SUB:   res = ax - bx;
         OPC_DEC:   res = ax - ONE;
         OPC_PASS:  res = ax;
         OPC_ROR:   res = {1'b0, a[0], a[DATA_W-1:1]};
         OPC_LSR:   res = {2'b00, a[DATA_W-1:1]};
         OPC_LSL:   res = {1'b0, a[DATA_W-2:0], 1'b0};
         OPC_SLX:   res = {1'b0, a[DATA_W-2:0], a[0]};
         OPC_OR:    res = {1'b0, a | b};
         OPC_XOR:   res = {1'b0, a ^ b};
         OPC_AND:   res = {1'b0, a & b};
         OPC_NOT:   res = {1'b0, ~a};
         OPC_STORE: res = ax;
         OPC_LDI:   res = {1'b0, imm};
         default:   res = '0;
      endcase
   end

endmodule

// File: rtl/execute_stage_p.sv
// Execute stage: forwards the previous result, captures operands, runs the ALU or an iterative multiplier.
// Latency: single-cycle ops 2 edges from accept to out_valid; MUL DATA_W+1 edges after accept.
// Backpressure: in_ready drops for the DATA_W+1 cycles of a multiply; decode must hold its instruction.
//
// Ports: clk/reset_n; in_valid/in_ready issue handshake with opcode_in, dest_in, s1_in, s2_in,
//        imm_in, data_s1_in, data_s2_in; out_valid pulse with result_out, flags_out {z,s,c},
//        dest_out, wr_en_out toward write-back.
module execute_stage_p
   import exec_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int OPC_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  opcode_in,
   input  logic [REG_AW-1:0] dest_in,
   input  logic [REG_AW-1:0] s1_in,
   input  logic [REG_AW-1:0] s2_in,
   input  logic [DATA_W-1:0] imm_in,
   input  logic [DATA_W-1:0] data_s1_in,
   input  logic [DATA_W-1:0] data_s2_in,
   output logic              out_valid,
   output logic [DATA_W-1:0] result_out,
   output logic [2:0]        flags_out,
   output logic [REG_AW-1:0] dest_out,
   output logic              wr_en_out
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   exec_state_t       state;
   exec_state_t       state_nxt;
   logic [CNT_W-1:0]  mul_cnt;

   opc_t              opc_in;
   logic              issue;
   logic              mul_start;
   logic              fwd_ok;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   // Operand capture stage for single-cycle ops
   logic              cap_vld;
   opc_t              cap_opc;
   logic [DATA_W-1:0] cap_a;
   logic [DATA_W-1:0] cap_b;
   logic [DATA_W-1:0] cap_imm;
   logic [REG_AW-1:0] cap_dest;

   // Shift-and-add multiplier: multiplicand moves left, multiplier right, full-width accumulator
   logic [2*DATA_W-1:0] mul_acc;
   logic [2*DATA_W-1:0] mul_mcand;
   logic [DATA_W-1:0]   mul_mplier;

   logic [DATA_W:0]   alu_res;
   logic              fin_vld;
   logic [DATA_W-1:0] fin_res;
   logic              fin_carry;
   logic              fin_wr;

   assign opc_in    = opc_t'(opcode_in);
   assign issue     = in_valid && in_ready;
   assign mul_start = issue && (opc_in == OPC_MUL);

   // Only a completed, writing instruction is a forwarding source; it is whatever sits on
   // the output registers in the issue cycle.
   assign fwd_ok = out_valid && wr_en_out;
   assign op_a   = (fwd_ok && (dest_out == s1_in)) ? result_out : data_s1_in;
   assign op_b   = (fwd_ok && (dest_out == s2_in)) ? result_out : data_s2_in;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && (opc_in == OPC_MUL)) begin
               state_nxt = ST_MUL_RUN;
            end
         end
         ST_MUL_RUN: begin
            // The last multiplier bit is consumed on the edge that sees the count at 1.
            if (mul_cnt == CNT_W'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------- Operand capture ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_vld  <= 1'b0;
         cap_opc  <= OPC_NOP;
         cap_a    <= '0;
         cap_b    <= '0;
         cap_imm  <= '0;
         cap_dest <= '0;
      end else begin
         cap_vld <= issue && (opc_in != OPC_MUL);
         if (issue) begin
            // cap_dest also serves as the MUL destination: nothing else issues while multiplying.
            cap_opc  <= opc_in;
            cap_a    <= op_a;
            cap_b    <= op_b;
            cap_imm  <= imm_in;
            cap_dest <= dest_in;
         end
      end
   end

   // ---------------- Multiplier datapath ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_cnt    <= '0;
         mul_acc    <= '0;
         mul_mcand  <= '0;
         mul_mplier <= '0;
      end else if (mul_start) begin
         mul_cnt    <= CNT_W'(DATA_W);
         mul_acc    <= '0;
         mul_mcand  <= {{DATA_W{1'b0}}, op_a};
         mul_mplier <= op_b;
      end else if (state == ST_MUL_RUN) begin
         if (mul_mplier[0]) begin
            mul_acc <= mul_acc + mul_mcand;
         end
         mul_mcand  <= mul_mcand << 1;
         mul_mplier <= mul_mplier >> 1;
         mul_cnt    <= mul_cnt - CNT_W'(1);
      end
   end

   // ---------------- ALU ----------------
   exec_alu_p #(
      .DATA_W (DATA_W)
   ) u_alu (
      .opc (cap_opc),
      .a   (cap_a),
      .b   (cap_b),
      .imm (cap_imm),
      .res (alu_res)
   );

   // A captured single-cycle op and a finishing MUL never coincide: capture only
   // happens from IDLE and DONE is always preceded by MUL_RUN.
   assign fin_vld   = (state == ST_DONE) || cap_vld;
   assign fin_res   = (state == ST_DONE) ? mul_acc[DATA_W-1:0] : alu_res[DATA_W-1:0];
   assign fin_carry = (state == ST_DONE) ? (|mul_acc[2*DATA_W-1:DATA_W]) : alu_res[DATA_W];
   assign fin_wr    = (state == ST_DONE) ? 1'b1 : opc_writes(cap_opc);

   // ---------------- Output registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid  <= 1'b0;
         result_out <= '0;
         flags_out  <= '0;
         dest_out   <= '0;
         wr_en_out  <= 1'b0;
      end else begin
         out_valid <= fin_vld;
         if (fin_vld) begin
            result_out        <= fin_res;
            flags_out[FLAG_Z] <= ~(|fin_res);
            flags_out[FLAG_S] <= fin_res[DATA_W-1];
            flags_out[FLAG_C] <= fin_carry;
            dest_out          <= cap_dest;
            wr_en_out         <= fin_wr;
         end
      end
   end

endmodule
